// File: rtl/iq_tune_ctrl_if.sv
// rtl/iq_tune_ctrl_if.sv - retune request channel between a tuning master and iq_tune_ctrl
interface iq_tune_ctrl_if #(
    parameter int CH_BITS = 6
);
    logic               req_valid;
    logic [CH_BITS-1:0] req_ch;
    logic               req_ready;
    logic               ch_err;

    modport master (
        output req_valid,
        output req_ch,
        input  req_ready,
        input  ch_err
    );

    modport slave (
        input  req_valid,
        input  req_ch,
        output req_ready,
        output ch_err
    );
endinterface

// File: rtl/iq_tune_ctrl.sv
// rtl/iq_tune_ctrl.sv - channel retune sequencer: LO word calc, demod flush, settle and lock
module iq_tune_ctrl #(
    parameter int CH_BITS    = 6,
    parameter int CH_MAX     = 40,
    parameter int FLUSH_CYC  = 4,
    parameter int SETTLE_CYC = 256
) (
    input  logic               clk_in,
    input  logic               RST,
    input  logic [31:0]        base_fre,
    input  logic [31:0]        step_fre,
    iq_tune_ctrl_if.slave      req,
    output logic [31:0]        LO_fre,
    output logic               demod_rst,
    output logic               out_en,
    output logic               locked,
    output logic [CH_BITS-1:0] cur_ch
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        FLUSH  = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4
    } state_t;

    localparam logic [CH_BITS-1:0] CH_LIMIT    = CH_BITS'(CH_MAX);
    localparam logic [15:0]        FLUSH_LAST  = 16'(FLUSH_CYC - 1);
    localparam logic [15:0]        SETTLE_LAST = 16'(SETTLE_CYC - 1);

    state_t             state, state_nxt;
    logic [15:0]        cnt, cnt_nxt;
    logic [CH_BITS-1:0] ch_lat;
    logic               lat_ch;
    logic               err_nxt, ch_err_q;
    logic               armed;
    logic               ready;
    logic               handshake;
    logic [31:0]        calc_fre;

    assign calc_fre      = base_fre + 32'(ch_lat) * step_fre;
    assign handshake     = req.req_valid & ready;
    assign req.req_ready = ready;
    assign req.ch_err    = ch_err_q;

    // armed keeps req_ready low until the first clock edge after reset release
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            ch_lat   <= '0;
            LO_fre   <= 32'd0;
            cur_ch   <= '0;
            ch_err_q <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ch_err_q <= err_nxt;
            armed    <= 1'b1;
            if (lat_ch) begin
                ch_lat <= req.req_ch;
            end
            if (state == CALC) begin
                LO_fre <= calc_fre;
                cur_ch <= ch_lat;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        lat_ch    = 1'b0;
        ready     = 1'b0;
        demod_rst = 1'b0;
        out_en    = 1'b0;
        locked    = 1'b0;
        case (state)
            IDLE, LOCKED: begin
                ready = armed;
                if (state == IDLE) begin
                    demod_rst = 1'b1;
                end else begin
                    out_en = 1'b1;
                    locked = 1'b1;
                end
                if (handshake) begin
                    if (req.req_ch <= CH_LIMIT) begin
                        lat_ch    = 1'b1;
                        state_nxt = CALC;
                        cnt_nxt   = 16'd0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            CALC: begin
                state_nxt = FLUSH;
                cnt_nxt   = 16'd0;
            end
            FLUSH: begin
                demod_rst = 1'b1;
                if (cnt == FLUSH_LAST) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = LOCKED;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end
endmodule
